uart_tx_ctrl: RTL

Frame controller for the UART transmitter. It accepts a parallel word, strobes the parity calculator, and serializes a start bit, the data bits (LSB first), an optional parity bit and a stop bit onto the serial line. It holds the only frame state machine in the TX path. The parity calculator is a separate instance, fed from this block's `PAR_LOAD` and returning `PAR_BIT`.

---
 rtl/uart_tx_ctrl_if.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and serial-line bundle between a UART TX frame controller and its neighbours.
// Master drives the word, request and parity bit; slave returns the parity load strobe, line and busy.
interface uart_tx_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] p_data;
  logic             data_valid;
  logic             par_en;
  logic             par_bit;
  logic             par_load;
  logic             tx_out;
  logic             busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_bit,
    input  par_load,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_bit,
    output par_load,
    output tx_out,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start bit, LSB-first data, optional parity, stop bit; one bit per clock.
// Line is registered one edge after accept; requests are taken only in IDLE and ignored mid-frame.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_ctrl_if.slave io_tx
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_par_en;
  logic             r_tx;
  logic             r_busy;
  logic             w_accept;
  logic             w_tx;
  logic             w_busy;

  // Gated by reset so the parity calculator never sees a load while reset is held.
  assign w_accept       = io_tx.data_valid & (r_state == S_IDLE) & ~i_rst;
  assign io_tx.par_load = w_accept;
  assign io_tx.tx_out   = r_tx;
  assign io_tx.busy     = r_busy;

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_START;
      S_START:  w_next = S_DATA;
      S_DATA:   if (r_cnt == LAST) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: w_next = S_STOP;
      S_STOP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // Line and busy are decoded from the next state so they change on the same edge as it.
    case (w_next)
      S_IDLE:   w_busy = 1'b0;
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = r_shift[0];
      S_PARITY: w_tx = io_tx.par_bit;
      S_STOP:   w_tx = 1'b1;
      default: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_par_en <= 1'b0;
    end else if (w_accept) begin
      r_shift  <= io_tx.p_data;
      r_cnt    <= '0;
      r_par_en <= io_tx.par_en;
    end else begin
      if (w_next == S_DATA) r_shift <= r_shift >> 1;
      if (r_state == S_DATA && r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule
